// File: rtl/axis_to_mem_writer.sv
// axis_to_mem_writer
// Captures an AXI-Stream into a memory buffer using AXI4 write bursts of
// up to BURST_LEN 64-byte beats, with one burst in flight at a time.
//
// Ports
//   mem_clk, rstn          : clock, asynchronous active-low reset
//   start                  : pulse that arms a capture (honoured in IDLE/DONE)
//   base_addr              : buffer byte address (aligned down to a burst)
//   buf_beats              : buffer size in 64-byte beats
//   pkt_target             : packets to capture, 0 = unlimited
//   from_app_t*            : 512-bit AXI-Stream input
//   to_mem_aw*/w*/b*       : AXI4 write address/data/response channels
//   busy, done, wr_err     : status flags
//   pkt_cnt, beats_written : status counters
module axis_to_mem_writer #(
  parameter int BURST_LEN = 16
) (
  input  logic         mem_clk,
  input  logic         rstn,
  input  logic         start,
  input  logic [63:0]  base_addr,
  input  logic [31:0]  buf_beats,
  input  logic [31:0]  pkt_target,
  input  logic [511:0] from_app_tdata,
  input  logic [63:0]  from_app_tkeep,
  input  logic         from_app_tlast,
  input  logic         from_app_tvalid,
  output logic         from_app_tready,
  output logic [63:0]  to_mem_awaddr,
  output logic [7:0]   to_mem_awlen,
  output logic [2:0]   to_mem_awsize,
  output logic [1:0]   to_mem_awburst,
  output logic         to_mem_awvalid,
  input  logic         to_mem_awready,
  output logic [511:0] to_mem_wdata,
  output logic [63:0]  to_mem_wstrb,
  output logic         to_mem_wlast,
  output logic         to_mem_wvalid,
  input  logic         to_mem_wready,
  input  logic [1:0]   to_mem_bresp,
  input  logic         to_mem_bvalid,
  output logic         to_mem_bready,
  output logic         busy,
  output logic         done,
  output logic         wr_err,
  output logic [31:0]  pkt_cnt,
  output logic [31:0]  beats_written
);

  // Aligning the base to a full burst keeps every burst inside one 4 KB page.
  localparam logic [63:0] ALIGN_MASK = 64'(BURST_LEN * 64 - 1);
  localparam logic [7:0]  MAX_AWLEN  = 8'(BURST_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ARM, S_AW, S_W, S_PAD, S_B, S_DONE
  } state_t;

  state_t      r_state;
  logic [63:0] r_addr;
  logic [31:0] r_remaining;
  logic [31:0] r_pkt_target;
  logic [31:0] r_pkt_cnt;
  logic [31:0] r_beats_written;
  logic [7:0]  r_awlen;
  logic [7:0]  r_beat;       // beats already handshaken in the current burst
  logic        r_wr_err;

  logic        w_in_w;
  logic        w_in_pad;
  logic        w_data_fire;
  logic        w_burst_end;
  logic        w_target_hit;
  logic        w_target_done;
  logic [31:0] w_pkt_cnt_inc;
  logic [7:0]  w_first_awlen;
  logic [63:0] w_burst_bytes;
  logic [63:0] w_base_aligned;

  assign w_in_w         = (r_state == S_W);
  assign w_in_pad       = (r_state == S_PAD);
  assign w_data_fire    = w_in_w & from_app_tvalid & to_mem_wready;
  assign w_burst_end    = (r_beat == r_awlen);
  assign w_pkt_cnt_inc  = r_pkt_cnt + 32'd1;
  // The packet just closing is the last one wanted.
  assign w_target_hit   = from_app_tlast && (r_pkt_target != 32'd0) &&
                          (w_pkt_cnt_inc == r_pkt_target);
  assign w_target_done  = (r_pkt_target != 32'd0) && (r_pkt_cnt == r_pkt_target);
  assign w_first_awlen  = (r_remaining >= 32'(BURST_LEN)) ? MAX_AWLEN :
                          8'(r_remaining - 32'd1);
  assign w_burst_bytes  = ({56'd0, r_awlen} + 64'd1) << 6;
  assign w_base_aligned = base_addr & ~ALIGN_MASK;

  // Stream is passed straight through to the W channel while in W; pad
  // beats carry zero data with zero strobes.
  assign from_app_tready = w_in_w & to_mem_wready;
  assign to_mem_wvalid   = (w_in_w & from_app_tvalid) | w_in_pad;
  assign to_mem_wdata    = w_in_w ? from_app_tdata : '0;
  assign to_mem_wstrb    = w_in_w ? from_app_tkeep : '0;
  assign to_mem_wlast    = (w_in_w | w_in_pad) & w_burst_end;

  assign to_mem_awaddr  = r_addr;
  assign to_mem_awlen   = r_awlen;
  assign to_mem_awsize  = 3'b110;
  assign to_mem_awburst = 2'b01;
  assign to_mem_awvalid = (r_state == S_AW);
  assign to_mem_bready  = (r_state == S_B);

  assign busy          = (r_state == S_ARM) || (r_state == S_AW) || (r_state == S_W) ||
                         (r_state == S_PAD) || (r_state == S_B);
  assign done          = (r_state == S_DONE);
  assign wr_err        = r_wr_err;
  assign pkt_cnt       = r_pkt_cnt;
  assign beats_written = r_beats_written;

  always_ff @(posedge mem_clk or negedge rstn) begin
    if (!rstn) begin
      r_state         <= S_IDLE;
      r_addr          <= '0;
      r_remaining     <= '0;
      r_pkt_target    <= '0;
      r_pkt_cnt       <= '0;
      r_beats_written <= '0;
      r_awlen         <= '0;
      r_beat          <= '0;
      r_wr_err        <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_addr          <= w_base_aligned;
            r_remaining     <= buf_beats;
            r_pkt_target    <= pkt_target;
            r_pkt_cnt       <= '0;
            r_beats_written <= '0;
            r_wr_err        <= 1'b0;
            r_state         <= (buf_beats == 32'd0) ? S_DONE : S_ARM;
          end
        end
        S_ARM: begin
          // Only open a burst once data is actually available.
          if (from_app_tvalid) begin
            r_awlen <= w_first_awlen;
            r_beat  <= '0;
            r_state <= S_AW;
          end
        end
        S_AW: begin
          if (to_mem_awready) r_state <= S_W;
        end
        S_W: begin
          if (w_data_fire) begin
            r_beats_written <= r_beats_written + 32'd1;
            r_remaining     <= r_remaining - 32'd1;
            r_beat          <= r_beat + 8'd1;
            if (from_app_tlast) r_pkt_cnt <= w_pkt_cnt_inc;
            if (w_burst_end)       r_state <= S_B;
            else if (w_target_hit) r_state <= S_PAD;
          end
        end
        S_PAD: begin
          if (to_mem_wready) begin
            r_beat <= r_beat + 8'd1;
            if (w_burst_end) r_state <= S_B;
          end
        end
        S_B: begin
          if (to_mem_bvalid) begin
            r_addr <= r_addr + w_burst_bytes;
            if (to_mem_bresp != 2'b00) r_wr_err <= 1'b1;
            r_state <= (w_target_done || (r_remaining == 32'd0)) ? S_DONE : S_ARM;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_to_mem_writer.sv
module tb_axis_to_mem_writer;

  localparam int BL = 16;

  logic         mem_clk = 1'b0;
  logic         rstn = 1'b0;
  logic         start = 1'b0;
  logic [63:0]  base_addr = '0;
  logic [31:0]  buf_beats = '0;
  logic [31:0]  pkt_target = '0;
  logic [511:0] from_app_tdata = '0;
  logic [63:0]  from_app_tkeep = '0;
  logic         from_app_tlast = 1'b0;
  logic         from_app_tvalid = 1'b0;
  logic         from_app_tready;
  logic [63:0]  to_mem_awaddr;
  logic [7:0]   to_mem_awlen;
  logic [2:0]   to_mem_awsize;
  logic [1:0]   to_mem_awburst;
  logic         to_mem_awvalid;
  logic         to_mem_awready = 1'b0;
  logic [511:0] to_mem_wdata;
  logic [63:0]  to_mem_wstrb;
  logic         to_mem_wlast;
  logic         to_mem_wvalid;
  logic         to_mem_wready = 1'b0;
  logic [1:0]   to_mem_bresp = 2'b00;
  logic         to_mem_bvalid = 1'b0;
  logic         to_mem_bready;
  logic         busy, done, wr_err;
  logic [31:0]  pkt_cnt, beats_written;

  axis_to_mem_writer #(.BURST_LEN(BL)) dut (
    .mem_clk(mem_clk), .rstn(rstn), .start(start),
    .base_addr(base_addr), .buf_beats(buf_beats), .pkt_target(pkt_target),
    .from_app_tdata(from_app_tdata), .from_app_tkeep(from_app_tkeep),
    .from_app_tlast(from_app_tlast), .from_app_tvalid(from_app_tvalid),
    .from_app_tready(from_app_tready),
    .to_mem_awaddr(to_mem_awaddr), .to_mem_awlen(to_mem_awlen),
    .to_mem_awsize(to_mem_awsize), .to_mem_awburst(to_mem_awburst),
    .to_mem_awvalid(to_mem_awvalid), .to_mem_awready(to_mem_awready),
    .to_mem_wdata(to_mem_wdata), .to_mem_wstrb(to_mem_wstrb),
    .to_mem_wlast(to_mem_wlast), .to_mem_wvalid(to_mem_wvalid),
    .to_mem_wready(to_mem_wready),
    .to_mem_bresp(to_mem_bresp), .to_mem_bvalid(to_mem_bvalid),
    .to_mem_bready(to_mem_bready),
    .busy(busy), .done(done), .wr_err(wr_err),
    .pkt_cnt(pkt_cnt), .beats_written(beats_written)
  );

  always #5 mem_clk = ~mem_clk;

  int total = 0;
  int bad = 0;

  // Stream to offer and expected memory-side traffic.
  logic [511:0] st_data[$];
  logic [63:0]  st_keep[$];
  logic         st_last[$];
  logic [63:0]  exp_aw_addr[$];
  logic [7:0]   exp_aw_len[$];
  logic [511:0] exp_w_data[$];
  logic [63:0]  exp_w_strb[$];
  logic         exp_w_last[$];
  int           exp_bw, exp_pk;
  logic         exp_err;
  logic [1:0]   b_resp_tab[64];

  int  st_gen = 0;   // bumped by the main process to make the driver reload
  int  s_idx = 0;    // stream beats consumed (driver owned)
  int  b_idx = 0;    // bursts responded (driver owned)
  int  w_seen = 0;   // data-bearing W handshakes (monitor owned)
  bit  stall = 0;

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [511:0] rand512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // lastdiv = 0: no packet boundaries; otherwise tlast with probability 1/lastdiv.
  task automatic make_stream(input int n, input int lastdiv);
    st_data.delete(); st_keep.delete(); st_last.delete();
    for (int i = 0; i < n; i++) begin
      st_data.push_back(rand512());
      st_keep.push_back({$urandom, $urandom});
      st_last.push_back(lastdiv != 0 && $urandom_range(0, lastdiv - 1) == 0);
    end
  endtask

  // Behavioural model: walk the buffer burst by burst, fill each burst from
  // the stream until the packet target is met, then zero-pad the remainder.
  task automatic build_model(input logic [63:0] base, input int unsigned bufb,
                             input int unsigned tgt);
    logic [63:0] addr;
    int unsigned rem, pk, ci, len, nb;
    bit stop;
    exp_aw_addr.delete(); exp_aw_len.delete();
    exp_w_data.delete(); exp_w_strb.delete(); exp_w_last.delete();
    addr = base - (base % 64'(BL * 64));
    rem = bufb; pk = 0; ci = 0; nb = 0; stop = 0; exp_err = 0;
    while (rem > 0 && !stop) begin
      len = (rem < BL) ? rem : BL;
      exp_aw_addr.push_back(addr);
      exp_aw_len.push_back(8'(len - 1));
      if (b_resp_tab[nb] != 2'b00) exp_err = 1;
      nb++;
      for (int k = 0; k < int'(len); k++) begin
        if (!stop && ci < st_data.size()) begin
          exp_w_data.push_back(st_data[ci]);
          exp_w_strb.push_back(st_keep[ci]);
          if (st_last[ci]) pk++;
          ci++; rem--;
          if (tgt != 0 && pk == tgt) stop = 1;
        end else begin
          exp_w_data.push_back('0);
          exp_w_strb.push_back('0);
        end
        exp_w_last.push_back(k == int'(len) - 1);
      end
      addr = addr + 64'(len) * 64;
    end
    exp_bw = int'(ci);
    exp_pk = int'(pk);
  endtask

  // Stream source plus AXI slave (AW/W ready, B response).
  initial begin
    bit tfire, bfire, wlfire;
    int my_gen;
    int b_pend;
    my_gen = 0; b_pend = 0;
    forever begin
      @(negedge mem_clk);
      tfire  = from_app_tvalid && from_app_tready;
      bfire  = to_mem_bvalid && to_mem_bready;
      wlfire = to_mem_wvalid && to_mem_wready && to_mem_wlast;
      @(posedge mem_clk);
      #1;
      if (!rstn || my_gen != st_gen) begin
        my_gen = st_gen;
        s_idx = 0; b_idx = 0; b_pend = 0;
        from_app_tvalid = 1'b0;
        to_mem_bvalid = 1'b0; to_mem_bresp = 2'b00;
        to_mem_awready = 1'b0; to_mem_wready = 1'b0;
      end else begin
        if (tfire) s_idx++;
        if (from_app_tvalid && !tfire) begin
          // hold the current beat until it is taken
        end else if (s_idx < st_data.size() && (!stall || $urandom_range(0, 3) != 0)) begin
          from_app_tvalid = 1'b1;
          from_app_tdata  = st_data[s_idx];
          from_app_tkeep  = st_keep[s_idx];
          from_app_tlast  = st_last[s_idx];
        end else begin
          from_app_tvalid = 1'b0;
        end
        to_mem_awready = stall ? ($urandom_range(0, 2) == 0) : 1'b1;
        to_mem_wready  = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
        if (wlfire) b_pend++;
        if (bfire) begin
          b_pend--; b_idx++;
          to_mem_bvalid = 1'b0;
        end
        if (!to_mem_bvalid && b_pend > 0 && (!stall || $urandom_range(0, 2) == 0)) begin
          to_mem_bvalid = 1'b1;
          to_mem_bresp  = b_resp_tab[b_idx % 64];
        end
      end
    end
  end

  // Compare process: every cycle, checks handshakes against the model queues,
  // stream pass-through, and stability of stalled AW/W channels.
  initial begin
    bit aw_hold, w_hold;
    logic [63:0]  h_awaddr;
    logic [7:0]   h_awlen;
    logic [511:0] h_wdata;
    logic [63:0]  h_wstrb;
    logic         h_wlast;
    aw_hold = 0; w_hold = 0;
    forever begin
      @(negedge mem_clk);
      if (!rstn) begin
        aw_hold = 0; w_hold = 0;
      end else begin
        chk("awsize_const", to_mem_awsize, 3'b110);
        chk("awburst_const", to_mem_awburst, 2'b01);
        if (aw_hold) begin
          chk("aw_stall_valid", to_mem_awvalid, 1'b1);
          chk("aw_stall_addr", to_mem_awaddr, h_awaddr);
          chk("aw_stall_len", to_mem_awlen, h_awlen);
        end
        if (w_hold) begin
          chk("w_stall_valid", to_mem_wvalid, 1'b1);
          chk("w_stall_data", to_mem_wdata, h_wdata);
          chk("w_stall_strb", to_mem_wstrb, h_wstrb);
          chk("w_stall_last", to_mem_wlast, h_wlast);
        end
        if (from_app_tready) begin
          chk("pass_wvalid", to_mem_wvalid, from_app_tvalid);
          chk("pass_wdata", to_mem_wdata, from_app_tdata);
          chk("pass_wstrb", to_mem_wstrb, from_app_tkeep);
        end
        if (to_mem_awvalid && to_mem_awready) begin
          chk("aw_expected", 32'(exp_aw_addr.size() != 0), 32'd1);
          if (exp_aw_addr.size() != 0) begin
            $display("aw addr=%h len=%0d", to_mem_awaddr, to_mem_awlen);
            chk("aw_addr", to_mem_awaddr, exp_aw_addr.pop_front());
            chk("aw_len", to_mem_awlen, exp_aw_len.pop_front());
          end
        end
        if (to_mem_wvalid && to_mem_wready) begin
          chk("w_expected", 32'(exp_w_data.size() != 0), 32'd1);
          if (exp_w_data.size() != 0) begin
            chk("w_data", to_mem_wdata, exp_w_data.pop_front());
            chk("w_strb", to_mem_wstrb, exp_w_strb.pop_front());
            chk("w_last", to_mem_wlast, exp_w_last.pop_front());
          end
          if (from_app_tready) w_seen++;
        end
        aw_hold = to_mem_awvalid && !to_mem_awready;
        w_hold  = to_mem_wvalid && !to_mem_wready;
        h_awaddr = to_mem_awaddr; h_awlen = to_mem_awlen;
        h_wdata = to_mem_wdata; h_wstrb = to_mem_wstrb; h_wlast = to_mem_wlast;
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    $display("reset check %s", tag);
    chk({tag, "_tready"}, from_app_tready, 1'b0);
    chk({tag, "_awaddr"}, to_mem_awaddr, 64'd0);
    chk({tag, "_awlen"}, to_mem_awlen, 8'd0);
    chk({tag, "_awsize"}, to_mem_awsize, 3'b110);
    chk({tag, "_awburst"}, to_mem_awburst, 2'b01);
    chk({tag, "_awvalid"}, to_mem_awvalid, 1'b0);
    chk({tag, "_wdata"}, to_mem_wdata, 512'd0);
    chk({tag, "_wstrb"}, to_mem_wstrb, 64'd0);
    chk({tag, "_wlast"}, to_mem_wlast, 1'b0);
    chk({tag, "_wvalid"}, to_mem_wvalid, 1'b0);
    chk({tag, "_bready"}, to_mem_bready, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_wr_err"}, wr_err, 1'b0);
    chk({tag, "_pkt_cnt"}, pkt_cnt, 32'd0);
    chk({tag, "_beats_written"}, beats_written, 32'd0);
  endtask

  task automatic prepare(input logic [63:0] base, input int unsigned bufb,
                         input int unsigned tgt, input bit st);
    stall = st;
    build_model(base, bufb, tgt);
    st_gen++;
    repeat (2) @(negedge mem_clk);
  endtask

  task automatic pulse_start(input logic [63:0] base, input int unsigned bufb,
                             input int unsigned tgt);
    base_addr = base; buf_beats = bufb; pkt_target = tgt;
    start = 1'b1;
    @(negedge mem_clk);
    start = 1'b0;
  endtask

  task automatic finish_capture(input logic [63:0] base, input int unsigned bufb,
                                input int unsigned tgt);
    int n;
    n = 0;
    while (!done && n < 5000) begin
      @(negedge mem_clk);
      n++;
    end
    chk("done_reached", done, 1'b1);
    repeat (6) begin
      @(negedge mem_clk);
      chk("tready_after_done", from_app_tready, 1'b0);
    end
    chk("done_held", done, 1'b1);
    chk("busy_at_done", busy, 1'b0);
    chk("beats_written", beats_written, exp_bw);
    chk("pkt_cnt", pkt_cnt, exp_pk);
    chk("wr_err", wr_err, exp_err);
    chk("beats_consumed", s_idx, exp_bw);
    chk("aw_outstanding", exp_aw_addr.size(), 0);
    chk("w_outstanding", exp_w_data.size(), 0);
    $display("capture base=%h buf=%0d tgt=%0d bw=%0d pk=%0d err=%0d",
             base, bufb, tgt, beats_written, pkt_cnt, wr_err);
  endtask

  task automatic run_capture(input logic [63:0] base, input int unsigned bufb,
                             input int unsigned tgt, input bit st);
    prepare(base, bufb, tgt, st);
    pulse_start(base, bufb, tgt);
    chk("start_busy", busy, bufb != 0);
    chk("start_done", done, bufb == 0);
    chk("start_wr_err", wr_err, 1'b0);
    chk("start_pkt_cnt", pkt_cnt, 32'd0);
    chk("start_beats", beats_written, 32'd0);
    finish_capture(base, bufb, tgt);
  endtask

  initial begin
    int n, w0;
    for (int i = 0; i < 64; i++) b_resp_tab[i] = 2'b00;
    #2;
    check_reset_outputs("por");
    repeat (3) @(negedge mem_clk);
    rstn = 1'b1;
    @(negedge mem_clk);

    // Two full bursts from 0x1000, extra stream beats left unconsumed.
    make_stream(40, 0);
    build_model(64'h1000, 32, 0);
    chk("pin1_aw_count", exp_aw_addr.size(), 2);
    chk("pin1_aw0", exp_aw_addr[0], 64'h1000);
    chk("pin1_aw1", exp_aw_addr[1], 64'h1400);
    chk("pin1_len0", exp_aw_len[0], 8'd15);
    chk("pin1_bw", exp_bw, 32);
    run_capture(64'h1000, 32, 0, 0);

    // One 5-beat packet closes the capture; the burst is zero-padded.
    make_stream(24, 0);
    st_last[4] = 1'b1;
    build_model(64'hABCD_0000_0000_07C0, 64, 1);
    chk("pin2_aw0", exp_aw_addr[0], 64'hABCD_0000_0000_0400);
    chk("pin2_w_count", exp_w_data.size(), 16);
    chk("pin2_pad_strb", exp_w_strb[5], 64'd0);
    chk("pin2_wlast15", exp_w_last[15], 1'b1);
    chk("pin2_bw", exp_bw, 5);
    chk("pin2_pk", exp_pk, 1);
    run_capture(64'hABCD_0000_0000_07C0, 64, 1, 0);

    // Short final burst.
    make_stream(30, 0);
    build_model(64'h8000, 20, 0);
    chk("pin3_len1", exp_aw_len[1], 8'd3);
    chk("pin3_bw", exp_bw, 20);
    run_capture(64'h8000, 20, 0, 0);

    // Random stalls on every channel with packet boundaries.
    make_stream(60, 5);
    run_capture(64'h0002_0000, 50, 3, 1);

    // Error response on the first burst; capture carries on.
    b_resp_tab[0] = 2'b10;
    make_stream(56, 0);
    build_model(64'h4000, 48, 0);
    chk("pin5_err", exp_err, 1'b1);
    run_capture(64'h4000, 48, 0, 1);
    b_resp_tab[0] = 2'b00;

    // Address wrap at the top of the 64-bit space.
    make_stream(52, 0);
    build_model(64'hFFFF_FFFF_FFFF_F800, 48, 0);
    chk("pin6_wrap", exp_aw_addr[2], 64'd0);
    run_capture(64'hFFFF_FFFF_FFFF_F800, 48, 0, 1);

    // Zero-size buffer goes straight to done.
    make_stream(4, 0);
    run_capture(64'h7000, 0, 0, 0);

    // Randomised captures.
    for (int t = 0; t < 4; t++) begin
      int unsigned rb, rt;
      rb = $urandom_range(1, 70);
      rt = $urandom_range(0, 4);
      make_stream(int'(rb) + 8, 6);
      run_capture({$urandom, $urandom}, rb, rt, 1);
    end

    // Reset while data beats are flowing, then a fresh capture.
    make_stream(40, 0);
    prepare(64'h5000, 40, 0, 0);
    w0 = w_seen;
    pulse_start(64'h5000, 40, 0);
    n = 0;
    while (w_seen - w0 < 3 && n < 500) begin
      @(negedge mem_clk);
      n++;
    end
    chk("mid_w_reached", 32'(w_seen - w0 >= 3), 32'd1);
    @(posedge mem_clk);
    #3 rstn = 1'b0;
    #1 check_reset_outputs("mid_w");
    exp_aw_addr.delete(); exp_aw_len.delete();
    exp_w_data.delete(); exp_w_strb.delete(); exp_w_last.delete();
    repeat (2) @(negedge mem_clk);
    rstn = 1'b1;
    make_stream(36, 4);
    run_capture(64'h0009_0000, 30, 2, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
